// File: rtl/sdram_ctrl_pkg.sv
// Shared types for the SDRAM controller: pin-level command encodings and sequencer states.
package sdram_ctrl_pkg;

    // Bits [2:0] are {RAS#, CAS#, WE#}. Bit 3 only tells PREA apart from PRE;
    // the pin driver drops it and uses A10 instead.
    typedef enum logic [3:0] {
        CMD_NOP  = 4'b0111,
        CMD_ACT  = 4'b0011,
        CMD_RD   = 4'b0101,
        CMD_WR   = 4'b0100,
        CMD_PRE  = 4'b0010,
        CMD_PREA = 4'b1010
    } sdram_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE_WAIT,
        S_ACT_WAIT,
        S_PREA_WAIT
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_open_row_table.sv
// Per-bank open-row tracking: a valid bit and row tag per bank, with a
// combinational hit/valid lookup.
module sdram_open_row_table #(
    parameter int BA_SIZE   = 2,
    parameter int MAX_RSIZE = 13
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BA_SIZE-1:0]   bank_i,
    input  logic [MAX_RSIZE-1:0] row_i,
    input  logic                 set_i,
    input  logic                 clr_i,
    input  logic                 clr_all_i,
    output logic                 valid_o,
    output logic                 hit_o
);
    localparam int NB = 1 << BA_SIZE;

    logic [NB-1:0]        valid_q;
    logic [MAX_RSIZE-1:0] tag_q [NB];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int b = 0; b < NB; b++) tag_q[b] <= '0;
        end else if (clr_all_i) begin
            valid_q <= '0;
        end else if (set_i) begin
            valid_q[bank_i] <= 1'b1;
            tag_q[bank_i]   <= row_i;
        end else if (clr_i) begin
            valid_q[bank_i] <= 1'b0;
        end
    end

    assign valid_o = valid_q[bank_i];
    assign hit_o   = valid_q[bank_i] && (tag_q[bank_i] == row_i);

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// Turns bank/row/column requests into PRECHARGE/ACTIVATE/READ/WRITE sequences,
// tracking open rows per bank; precharge-all requests take priority.
//
// state       | meaning
// S_IDLE      | sample requests; row hits issue RD/WR directly
// S_PRE_WAIT  | PRECHARGE issued, waiting TRP before ACTIVATE
// S_ACT_WAIT  | ACTIVATE issued, waiting TRCD before RD/WR
// S_PREA_WAIT | PRECHARGE-all issued, waiting TRP before pall_ack_o
module sdram_cmd_sequencer
    import sdram_ctrl_pkg::*;
#(
    parameter int BA_SIZE   = 2,
    parameter int MAX_RSIZE = 13,
    parameter int MAX_CSIZE = 11,
    parameter int TRP       = 3,
    parameter int TRCD      = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [BA_SIZE-1:0]   bank_i,
    input  logic [MAX_RSIZE-1:0] row_i,
    input  logic [MAX_CSIZE-1:0] column_i,
    output logic                 ack_o,
    input  logic                 pall_req_i,
    output logic                 pall_ack_o,
    output sdram_cmd_t           cmd_o,
    output logic [BA_SIZE-1:0]   cmd_ba_o,
    output logic [MAX_RSIZE-1:0] cmd_addr_o
);
    localparam int                   CW        = $clog2(max_int(TRP, TRCD) + 1);
    localparam logic [CW-1:0]        TRP_LOAD  = CW'(TRP - 1);
    localparam logic [CW-1:0]        TRCD_LOAD = CW'(TRCD - 1);
    localparam logic [MAX_RSIZE-1:0] A10_ADDR  = MAX_RSIZE'(1) << 10;

    seq_state_t           state_q, state_n;
    logic [CW-1:0]        cnt_q, cnt_n;
    sdram_cmd_t           cmd_n, col_cmd;
    logic [BA_SIZE-1:0]   ba_n;
    logic [MAX_RSIZE-1:0] addr_n, col_addr;
    logic                 ack_n, pall_ack_n;
    logic                 tbl_set, tbl_clr, tbl_clr_all, tbl_valid, tbl_hit;

    sdram_open_row_table #(
        .BA_SIZE   (BA_SIZE),
        .MAX_RSIZE (MAX_RSIZE)
    ) u_row_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .bank_i    (bank_i),
        .row_i     (row_i),
        .set_i     (tbl_set),
        .clr_i     (tbl_clr),
        .clr_all_i (tbl_clr_all),
        .valid_o   (tbl_valid),
        .hit_o     (tbl_hit)
    );

    // A10 is skipped so column commands never request auto-precharge.
    always_comb begin
        col_addr = '0;
        for (int i = 0; i < MAX_CSIZE; i++) begin
            col_addr[(i < 10) ? i : i + 1] = column_i[i];
        end
    end

    assign col_cmd = we_i ? CMD_WR : CMD_RD;

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        cmd_n       = CMD_NOP;
        ba_n        = cmd_ba_o;
        addr_n      = cmd_addr_o;
        ack_n       = 1'b0;
        pall_ack_n  = 1'b0;
        tbl_set     = 1'b0;
        tbl_clr     = 1'b0;
        tbl_clr_all = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The cycle carrying an ack still sees the old request; skip it.
                if (!ack_o && !pall_ack_o) begin
                    if (pall_req_i) begin
                        cmd_n       = CMD_PREA;
                        addr_n      = A10_ADDR;
                        tbl_clr_all = 1'b1;
                        cnt_n       = TRP_LOAD;
                        state_n     = S_PREA_WAIT;
                    end else if (req_i) begin
                        ba_n = bank_i;
                        if (tbl_hit) begin
                            cmd_n  = col_cmd;
                            addr_n = col_addr;
                            ack_n  = 1'b1;
                        end else if (!tbl_valid) begin
                            cmd_n   = CMD_ACT;
                            addr_n  = row_i;
                            tbl_set = 1'b1;
                            cnt_n   = TRCD_LOAD;
                            state_n = S_ACT_WAIT;
                        end else begin
                            cmd_n   = CMD_PRE;
                            addr_n  = '0;
                            tbl_clr = 1'b1;
                            cnt_n   = TRP_LOAD;
                            state_n = S_PRE_WAIT;
                        end
                    end
                end
            end
            S_PRE_WAIT: begin
                if (cnt_q == '0) begin
                    cmd_n   = CMD_ACT;
                    ba_n    = bank_i;
                    addr_n  = row_i;
                    tbl_set = 1'b1;
                    cnt_n   = TRCD_LOAD;
                    state_n = S_ACT_WAIT;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            S_ACT_WAIT: begin
                if (cnt_q == '0) begin
                    cmd_n   = col_cmd;
                    ba_n    = bank_i;
                    addr_n  = col_addr;
                    ack_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            S_PREA_WAIT: begin
                if (cnt_q == '0) begin
                    pall_ack_n = 1'b1;
                    state_n    = S_IDLE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cmd_o      <= CMD_NOP;
            cmd_ba_o   <= '0;
            cmd_addr_o <= '0;
            ack_o      <= 1'b0;
            pall_ack_o <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            cmd_o      <= cmd_n;
            cmd_ba_o   <= ba_n;
            cmd_addr_o <= addr_n;
            ack_o      <= ack_n;
            pall_ack_o <= pall_ack_n;
        end
    end

endmodule
